// File: rtl/witf_pkg.sv
// witf_pkg: shared definitions for the write-in-flight table.
//   REG_ADDR_BUS : architectural register-address width (the RegAddrBus define)
//   reg_addr_t   : register-address type
//   REG_ZERO     : index of the hard-wired zero register
//   src_hit()    : one source-operand comparison, zero register never hits
package witf_pkg;

    localparam int REG_ADDR_BUS = 5;

    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // x0 is never a real producer, so a zero source can never be a hazard.
    function automatic logic src_hit(input reg_addr_t entry, input reg_addr_t src);
        return (src != REG_ZERO) && (entry == src);
    endfunction

endpackage

// File: rtl/witf_cam.sv
// witf_cam: hazard lookup for the write-in-flight table.
// Compares every slot against both decode sources and masks out slots that
// are not currently in flight.
//   entries : all DEPTH stored destination registers (slot-indexed)
//   head    : slot index of the oldest valid entry
//   cnt     : number of valid entries starting at head
//   rs1/rs2 : source registers being read by decode
//   is_raw  : 1 when any valid entry matches a nonzero source
module witf_cam
    import witf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][REG_ADDR_BUS-1:0] entries,
    input  logic [AW-1:0]                      head,
    input  logic [AW:0]                        cnt,
    input  logic [REG_ADDR_BUS-1:0]            rs1,
    input  logic [REG_ADDR_BUS-1:0]            rs2,
    output logic                               is_raw
);

    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] hit_s;

    // Slot i is valid when its distance from head (mod DEPTH) is below cnt.
    always_comb begin
        valid_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off        = AW'(i) - head;
            valid_s[i] = ({1'b0, off} < cnt);
        end
    end

    // Per-slot comparators against both sources, qualified by the valid mask.
    always_comb begin
        hit_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i]) begin
                hit_s[i] = src_hit(entries[i], rs1) || src_hit(entries[i], rs2);
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    assign is_raw = |hit_s;

endmodule

// File: rtl/witf.sv
// witf: write-in-flight table (register-hazard scoreboard behind decode).
// Circular buffer of in-flight destination registers: decode pushes at the
// tail, writeback retires at the head, a flush with kill removes the youngest.
//   clk, rst              : clock, asynchronous active-high reset
//   disp_en, rd           : push request and destination register
//   rs1, rs2              : decode source registers for the hazard lookup
//   isRAW                 : read-after-write hazard on rs1/rs2
//   witf_full/empty/cnt   : occupancy, combinational from registered state
//   wb_en, wb_rd          : in-order retire and register being written back
//   flush_pipeline,kill_en: flush; with kill_en the youngest entry is removed
//   witf_err              : sticky protocol-violation flag
module witf
    import witf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_en,
    input  logic [REG_ADDR_BUS-1:0] rd,
    input  logic [REG_ADDR_BUS-1:0] rs1,
    input  logic [REG_ADDR_BUS-1:0] rs2,
    output logic                    isRAW,
    output logic                    witf_full,
    output logic                    witf_empty,
    output logic [AW:0]             witf_cnt,
    input  logic                    wb_en,
    input  logic [REG_ADDR_BUS-1:0] wb_rd,
    input  logic                    flush_pipeline,
    input  logic                    kill_en,
    output logic                    witf_err
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(1'b0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0][REG_ADDR_BUS-1:0] mem_q, mem_d;
    logic [AW-1:0]                      head_q, head_d;
    logic [AW-1:0]                      tail_q, tail_d;
    logic [AW:0]                        cnt_q, cnt_d;
    logic                               err_q, err_d;

    logic full_s;
    logic empty_s;
    logic kill_req_s;
    logic kill_blocked_s;
    logic do_push_s;
    logic do_retire_s;
    logic do_kill_s;
    logic head_mismatch_s;
    logic err_event_s;

    // Event qualification and protocol-violation detection.
    always_comb begin
        full_s          = (cnt_q == CNT_FULL);
        empty_s         = (cnt_q == CNT_ZERO);
        kill_req_s      = flush_pipeline & kill_en;
        do_retire_s     = wb_en & ~empty_s;
        // With one entry, retire and kill target the same slot: retire wins.
        kill_blocked_s  = kill_req_s & do_retire_s & (cnt_q == CNT_ONE);
        do_kill_s       = kill_req_s & ~empty_s & ~kill_blocked_s;
        // A kill always suppresses a same-cycle push, even with nothing to kill.
        do_push_s       = disp_en & ~full_s & ~kill_req_s;
        head_mismatch_s = (mem_q[head_q] != wb_rd);
        err_event_s     = (disp_en & (full_s | kill_req_s))
                        | (wb_en & empty_s)
                        | (do_retire_s & head_mismatch_s)
                        | kill_blocked_s;
    end

    // Next-state computation for storage, pointers, count and error flag.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q | err_event_s;

        if (do_push_s) begin
            mem_d[tail_q] = rd;
            tail_d        = tail_q + PTR_ONE;
        end else if (do_kill_s) begin
            tail_d = tail_q - PTR_ONE;
        end else begin
            tail_d = tail_q;
        end

        if (do_retire_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end

        cnt_d = cnt_q + (AW + 1)'(do_push_s)
                      - (AW + 1)'(do_retire_s)
                      - (AW + 1)'(do_kill_s);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            head_q <= {AW{1'b0}};
            tail_q <= {AW{1'b0}};
            cnt_q  <= CNT_ZERO;
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    witf_cam #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cam (
        .entries (mem_q),
        .head    (head_q),
        .cnt     (cnt_q),
        .rs1     (rs1),
        .rs2     (rs2),
        .is_raw  (isRAW)
    );

    assign witf_full  = full_s;
    assign witf_empty = empty_s;
    assign witf_cnt   = cnt_q;
    assign witf_err   = err_q;

endmodule

// File: tb/tb_witf.sv
// tb_witf: directed, table-driven bench for witf (DEPTH = 4).
// Each vector drives inputs after a falling edge and compares the
// combinational outputs before the next rising edge, so expected values
// describe the state left by all earlier vectors.
module tb_witf;

    logic       clk;
    logic       rst;
    logic       disp_en;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       isRAW;
    logic       witf_full;
    logic       witf_empty;
    logic [2:0] witf_cnt;
    logic       wb_en;
    logic [4:0] wb_rd;
    logic       flush_pipeline;
    logic       kill_en;
    logic       witf_err;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       pre_rst;
        logic       de;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       wb;
        logic [4:0] wbrd;
        logic       fl;
        logic       kl;
        int         cnt;
        logic       full;
        logic       empty;
        logic       raw;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    witf #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .disp_en        (disp_en),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .isRAW          (isRAW),
        .witf_full      (witf_full),
        .witf_empty     (witf_empty),
        .witf_cnt       (witf_cnt),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .flush_pipeline (flush_pipeline),
        .kill_en        (kill_en),
        .witf_err       (witf_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp_v);
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp_v);
        end
    endtask

    task automatic add(input logic pr, input logic de, input int r, input int s1, input int s2,
                       input logic wb, input int wr, input logic fl, input logic kl,
                       input int c, input logic f, input logic e, input logic rw, input logic er);
        vec_t v;
        v.pre_rst = pr; v.de = de; v.rd = 5'(r); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
        v.wb = wb; v.wbrd = 5'(wr); v.fl = fl; v.kl = kl;
        v.cnt = c; v.full = f; v.empty = e; v.raw = rw; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        disp_en = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        wb_en = 1'b0; wb_rd = 5'd0; flush_pipeline = 1'b0; kill_en = 1'b0;
    endtask

    initial begin
        //   pre de rd  rs1 rs2 wb wbrd fl kl | cnt full empty raw err
        // hazard and retire
        add(0, 1,  7,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 0,  0,  0,  7, 0,  0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0,  0,  7, 1,  7, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0,  0,  7, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        // wrap-around: seed one entry, then 10 push/retire pairs
        add(0, 1, 10,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1, 11,  7,  0, 1, 10, 0, 0,   1, 0, 0, 0, 0);
        add(0, 1, 12,  0, 11, 1, 11, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1, 13, 11,  0, 1, 12, 0, 0,   1, 0, 0, 0, 0);
        add(0, 1, 14,  0, 13, 1, 13, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1, 15, 13,  0, 1, 14, 0, 0,   1, 0, 0, 0, 0);
        add(0, 1, 16,  0, 15, 1, 15, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1, 17, 15,  0, 1, 16, 0, 0,   1, 0, 0, 0, 0);
        add(0, 1, 18,  0, 17, 1, 17, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1, 19, 17,  0, 1, 18, 0, 0,   1, 0, 0, 0, 0);
        add(0, 1, 20,  0, 19, 1, 19, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0, 20, 19, 0,  0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0, 19,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0,  0,  0,  0, 1, 20, 0, 0,   1, 0, 0, 0, 0);
        // flush kill
        add(0, 1,  3,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1,  4,  0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0,  0,  4,  0, 0,  0, 1, 1,   2, 0, 0, 1, 0);
        add(0, 0,  0,  4,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0,  0,  3,  0, 0,  0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0,  3,  0, 0,  0, 1, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0,  3,  0, 0,  0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 0,  0,  0,  0, 1,  3, 0, 0,   1, 0, 0, 0, 0);
        // order check
        add(0, 1,  8,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1,  9,  0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0);
        add(0, 0,  0,  9,  0, 1,  9, 0, 0,   2, 0, 0, 1, 0);
        add(0, 0,  0,  9,  0, 0,  0, 0, 0,   1, 0, 0, 1, 1);
        add(0, 0,  0,  8,  0, 0,  0, 0, 0,   1, 0, 0, 0, 1);
        // fill and overflow, then retire + kill with count 4
        add(1, 1,  1,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1,  2,  1,  0, 0,  0, 0, 0,   1, 0, 0, 1, 0);
        add(0, 1,  3,  0,  0, 0,  0, 0, 0,   2, 0, 0, 0, 0);
        add(0, 1,  4,  0,  0, 0,  0, 0, 0,   3, 0, 0, 0, 0);
        add(0, 1,  5,  0,  0, 0,  0, 0, 0,   4, 1, 0, 0, 0);
        add(0, 0,  0,  5,  0, 0,  0, 0, 0,   4, 1, 0, 0, 1);
        add(0, 0,  0,  4,  1, 0,  0, 0, 0,   4, 1, 0, 1, 1);
        add(0, 0,  0,  4,  0, 1,  1, 1, 1,   4, 1, 0, 1, 1);
        add(0, 0,  0,  4,  1, 0,  0, 0, 0,   2, 0, 0, 0, 1);
        add(0, 0,  0,  2,  3, 0,  0, 0, 0,   2, 0, 0, 1, 1);
        // retire while empty
        add(1, 0,  0,  0,  0, 1,  1, 0, 0,   0, 0, 1, 0, 0);
        add(0, 0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 1);
        // retire + kill with count 1: retire applies, error
        add(1, 1,  6,  0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 0,  0,  0,  0, 1,  6, 1, 1,   1, 0, 0, 0, 0);
        add(0, 0,  0,  6,  0, 0,  0, 0, 0,   0, 0, 1, 0, 1);
        // push + kill: kill wins, push dropped, error
        add(1, 1,  6,  0,  0, 0,  0, 1, 1,   0, 0, 1, 0, 0);
        add(0, 0,  0,  6,  0, 0,  0, 0, 0,   0, 0, 1, 0, 1);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation: three entries in flight, reset between edges.
        for (int k = 1; k <= 3; k++) begin
            disp_en = 1'b1; rd = 5'(k);
            @(negedge clk);
        end
        disp_en = 1'b0; rs1 = 5'd1;
        #1;
        n_vec++;
        chk("pre_rst_cnt", -1, int'(witf_cnt), 3);
        chk("pre_rst_raw", -1, int'(isRAW), 1);
        rst = 1'b1;
        #1;
        n_vec++;
        chk("async_rst_cnt",   -2, int'(witf_cnt), 0);
        chk("async_rst_empty", -2, int'(witf_empty), 1);
        chk("async_rst_full",  -2, int'(witf_full), 0);
        chk("async_rst_raw",   -2, int'(isRAW), 0);
        chk("async_rst_err",   -2, int'(witf_err), 0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            disp_en        = vecs[i].de;
            rd             = vecs[i].rd;
            rs1            = vecs[i].rs1;
            rs2            = vecs[i].rs2;
            wb_en          = vecs[i].wb;
            wb_rd          = vecs[i].wbrd;
            flush_pipeline = vecs[i].fl;
            kill_en        = vecs[i].kl;
            #1;
            n_vec++;
            chk("cnt",   i, int'(witf_cnt),   vecs[i].cnt);
            chk("full",  i, int'(witf_full),  int'(vecs[i].full));
            chk("empty", i, int'(witf_empty), int'(vecs[i].empty));
            chk("isRAW", i, int'(isRAW),      int'(vecs[i].raw));
            chk("err",   i, int'(witf_err),   int'(vecs[i].err));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
